// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store bus master.
//   SZ_BYTE/SZ_HALF/SZ_WORD : req_size_i encodings (2'b11 is reserved)
//   state_t                 : bus master FSM states
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      ERR  = 2'b11
   } state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational access shaping for the load/store unit.
//   size, addr, uns : access size, byte address, zero-extend flag
//   wdata           : LSB-aligned store data
//   rdata           : raw bus read data
//   be              : bus byte enables
//   bus_wdata       : store data replicated across the word
//   err             : reserved size, misaligned access or address out of range
//   load_data       : extracted and extended load result
module lsu_align
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic        uns,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] bus_wdata,
   output logic        err,
   output logic [31:0] load_data
);

   logic        misalign;
   logic        out_of_range;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Shifting by the bus width leaves zero, so this also covers ADDR_W = 32.
   assign out_of_range = |(addr >> ADDR_W);
   assign err          = misalign | out_of_range;

   assign byte_sel = rdata[{addr[1:0], 3'b000} +: 8];
   assign half_sel = rdata[{addr[1], 4'b0000} +: 16];

   always_comb begin
      be        = 4'b0000;
      bus_wdata = wdata;
      misalign  = 1'b0;
      load_data = rdata;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << addr[1:0];
            bus_wdata = {4{wdata[7:0]}};
            load_data = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            be        = 4'b0011 << {addr[1], 1'b0};
            bus_wdata = {2{wdata[15:0]}};
            misalign  = addr[0];
            load_data = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         SZ_WORD: begin
            be       = 4'b1111;
            misalign = |addr[1:0];
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: turns single pipeline load/store requests into
// data_req/gnt/rvalid bus transactions, one outstanding at a time.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   req_*                        : pipeline request (valid/ready handshake)
//   resp_valid/rdata/err_o       : registered one-cycle response
//   data_req/we/be/addr/wdata_o  : bus request side
//   data_gnt/rvalid/rdata_i      : bus grant and response
//
// state | meaning
// IDLE  | ready for a request; latch it on accept
// REQ   | data_req_o high, waiting for data_gnt_i
// WAIT  | granted, waiting for data_rvalid_i
// ERR   | one cycle, schedules an error response
module lsu_bus_master
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 14
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [31:0]       req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              resp_valid_o,
   output logic [31:0]       resp_rdata_o,
   output logic              resp_err_o,
   output logic              data_req_o,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [31:0]       data_wdata_o,
   input  logic              data_gnt_i,
   input  logic              data_rvalid_i,
   input  logic [31:0]       data_rdata_i
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q;
   logic [1:0]         size_q;
   logic               uns_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [31:0]        wdata_q;
   logic               resp_valid_q, resp_valid_d;
   logic               resp_err_q, resp_err_d;
   logic [31:0]        resp_rdata_q, resp_rdata_d;

   logic               in_idle, in_req;
   logic [1:0]         a_size;
   logic [31:0]        a_addr;
   logic               a_uns;
   logic [31:0]        a_wdata;
   logic [3:0]         a_be;
   logic [31:0]        a_bus_wdata;
   logic               a_err;
   logic [31:0]        a_load;

   assign in_idle = (state_q == IDLE);
   assign in_req  = (state_q == REQ);

   // In IDLE the aligner checks the incoming request; afterwards it works
   // on the latched copy so bus outputs come only from registers.
   assign a_size  = in_idle ? req_size_i     : size_q;
   assign a_addr  = in_idle ? req_addr_i     : {{(32-ADDR_W){1'b0}}, addr_q};
   assign a_uns   = in_idle ? req_unsigned_i : uns_q;
   assign a_wdata = in_idle ? req_wdata_i    : wdata_q;

   lsu_align #(.ADDR_W(ADDR_W)) u_align (
      .size      (a_size),
      .addr      (a_addr),
      .uns       (a_uns),
      .wdata     (a_wdata),
      .rdata     (data_rdata_i),
      .be        (a_be),
      .bus_wdata (a_bus_wdata),
      .err       (a_err),
      .load_data (a_load)
   );

   // Timer is a down-counter reloaded on every state entry; terminal count
   // zero means TIMEOUT_CYCLES cycles have been spent in the state.
   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'h0;
      case (state_q)
         IDLE: if (req_valid_i) state_d = a_err ? ERR : REQ;
         REQ: begin
            if (data_gnt_i)        state_d = WAIT;
            else if (cnt_q == '0)  state_d = ERR;
         end
         WAIT: begin
            if (data_rvalid_i) begin
               state_d      = IDLE;
               resp_valid_d = 1'b1;
               resp_rdata_d = we_q ? 32'h0 : a_load;
            end else if (cnt_q == '0) begin
               state_d = ERR;
            end
         end
         ERR: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      cnt_d = cnt_q;
      if (state_d != state_q)  cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
      else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         if (in_idle && req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i[ADDR_W-1:0];
            wdata_q <= req_wdata_i;
         end
      end
   end

   assign req_ready_o  = in_idle;
   assign resp_valid_o = resp_valid_q;
   assign resp_err_o   = resp_err_q;
   assign resp_rdata_o = resp_rdata_q;

   assign data_req_o   = in_req;
   assign data_we_o    = in_req & we_q;
   assign data_be_o    = in_req ? a_be : 4'b0000;
   assign data_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign data_wdata_o = (in_req && we_q) ? a_bus_wdata : 32'h0;

endmodule

// File: tb/tb_lsu_bus_master.sv
module tb_lsu_bus_master;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        data_gnt = 1'b0, data_rvalid = 1'b0;
   logic [31:0] data_rdata = 32'h0;

   logic        req_ready_o, resp_valid_o, resp_err_o;
   logic [31:0] resp_rdata_o;
   logic        data_req_o, data_we_o;
   logic [3:0]  data_be_o;
   logic [13:0] data_addr_o;
   logic [31:0] data_wdata_o;

   always #5 clk = ~clk;

   lsu_bus_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(14)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready_o),
      .req_we_i       (req_we),
      .req_size_i     (req_size),
      .req_unsigned_i (req_uns),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .resp_valid_o   (resp_valid_o),
      .resp_rdata_o   (resp_rdata_o),
      .resp_err_o     (resp_err_o),
      .data_req_o     (data_req_o),
      .data_we_o      (data_we_o),
      .data_be_o      (data_be_o),
      .data_addr_o    (data_addr_o),
      .data_wdata_o   (data_wdata_o),
      .data_gnt_i     (data_gnt),
      .data_rvalid_i  (data_rvalid),
      .data_rdata_i   (data_rdata)
   );

   int checks = 0;
   int errors = 0;

   // Observations from the last transaction.
   int          o_lat, o_nreq;
   logic        o_err, o_we, o_ready;
   logic [31:0] o_rdata, o_wdata;
   logic [3:0]  o_be;
   logic [13:0] o_addr;

   // Reference model: byte lanes, replication and extraction from first principles.
   function automatic logic [3:0] m_be(input logic [1:0] size, input int off);
      int nb = 1 << size;
      logic [3:0] r = 4'b0000;
      for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + nb);
      return r;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
      int nb = 1 << size;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nb) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] size, input int off,
                                          input logic uns, input logic [31:0] rd);
      int nb = 1 << size;
      longint v;
      if (nb == 4) return rd;
      v = (longint'(rd) >> (8 * off)) & ((64'sd1 <<< (8 * nb)) - 1);
      if (!uns && v >= (64'sd1 <<< (8 * nb - 1))) v = v - (64'sd1 <<< (8 * nb));
      return v[31:0];
   endfunction

   function automatic logic m_err(input logic [1:0] size, input logic [31:0] a);
      if (size == 2'b11) return 1'b1;
      if (size == 2'b01 && (a % 2) != 0) return 1'b1;
      if (size == 2'b10 && (a % 4) != 0) return 1'b1;
      return a >= 32'h4000;
   endfunction

   // Bus responder: grants in the (gnt_wait+1)-th request cycle and returns
   // rvalid rv_wait cycles after the grant. Starts and ends on a negedge.
   task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int gnt_wait, input int rv_wait);
      int  wcnt;
      bit  granted;
      o_ready = req_ready_o;
      req_valid = 1'b1; req_we = we; req_size = size; req_uns = uns;
      req_addr = addr; req_wdata = wdata; data_rdata = rdata;
      o_lat = -1; o_nreq = 0; o_err = 1'b0; o_we = 1'b0;
      o_rdata = 32'h0; o_wdata = 32'h0; o_be = 4'b0; o_addr = 14'h0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      granted = 1'b0;
      wcnt = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (data_req_o) begin
            o_nreq++;
            if (o_nreq == 1) begin
               o_be = data_be_o; o_addr = data_addr_o;
               o_wdata = data_wdata_o; o_we = data_we_o;
            end
         end
         if (resp_valid_o) begin
            o_lat = cyc; o_err = resp_err_o; o_rdata = resp_rdata_o;
            break;
         end
         data_gnt = 1'b0;
         data_rvalid = 1'b0;
         if (granted) begin
            if (wcnt == rv_wait) data_rvalid = 1'b1;
            wcnt++;
         end
         if (data_req_o && o_nreq > gnt_wait) begin
            data_gnt = 1'b1; granted = 1'b1; wcnt = 0;
         end
         @(negedge clk);
      end
      data_gnt = 1'b0;
      data_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready_o, resp_valid_o, resp_err_o, data_req_o, data_we_o} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got ready/rv/err/req/we=%b expected 10000",
                  {req_ready_o, resp_valid_o, resp_err_o, data_req_o, data_we_o});
      end
      checks++;
      if ({resp_rdata_o, data_wdata_o, data_addr_o, data_be_o} !== 82'h0) begin
         errors++;
         $display("FAIL reset_data: got rdata=%h wdata=%h addr=%h be=%b expected all 0",
                  resp_rdata_o, data_wdata_o, data_addr_o, data_be_o);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_word_store();
      run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h1111_1111, 0, 0);
      checks++;
      if ({o_be, o_addr, o_wdata, o_we} !== {4'b1111, 14'h104, 32'hDEAD_BEEF, 1'b1}) begin
         errors++;
         $display("FAIL word_store_bus: got be=%b addr=%h wdata=%h we=%b expected 1111 0104 deadbeef 1",
                  o_be, o_addr, o_wdata, o_we);
      end
      checks++;
      if (o_nreq !== 1 || o_lat !== 3 || o_err !== 1'b0 || o_rdata !== 32'h0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL word_store_resp: got nreq=%0d lat=%0d err=%b rdata=%h ready=%b expected 1 3 0 0 1",
                  o_nreq, o_lat, o_err, o_rdata, o_ready);
      end
   endtask

   task automatic test_byte_load();
      run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 32'h80FF_1234, 0, 0);
      checks++;
      if (o_be !== 4'b1000 || o_addr !== 14'h200 || o_we !== 1'b0) begin
         errors++;
         $display("FAIL byte_load_bus: got be=%b addr=%h we=%b expected 1000 0200 0", o_be, o_addr, o_we);
      end
      checks++;
      if (o_rdata !== 32'hFFFF_FF80 || o_lat !== 3 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL byte_load_signed: got rdata=%h lat=%0d err=%b expected ffffff80 3 0",
                  o_rdata, o_lat, o_err);
      end
      run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_1234, 0, 0);
      checks++;
      if (o_rdata !== 32'h0000_0080 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL byte_load_unsigned: got rdata=%h err=%b expected 00000080 0", o_rdata, o_err);
      end
   endtask

   task automatic test_half_store();
      run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_ABCD, 32'h0, 1, 2);
      checks++;
      if (o_be !== 4'b1100 || o_wdata !== 32'hABCD_ABCD || o_addr !== 14'h0) begin
         errors++;
         $display("FAIL half_store_bus: got be=%b wdata=%h addr=%h expected 1100 abcdabcd 0000",
                  o_be, o_wdata, o_addr);
      end
      checks++;
      if (o_nreq !== 2 || o_lat !== 6 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL half_store_resp: got nreq=%0d lat=%0d err=%b expected 2 6 0", o_nreq, o_lat, o_err);
      end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [3] = '{32'h0000_0006, 32'h0001_0000, 32'h0000_0000};
      logic [1:0]  sizes [3] = '{2'b10, 2'b10, 2'b11};
      for (int i = 0; i < 3; i++) begin
         run_txn(1'b0, sizes[i], 1'b0, addrs[i], 32'h0, 32'hFFFF_FFFF, 0, 0);
         checks++;
         if (o_nreq !== 0 || o_lat !== 2 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL err_resp[%0d]: got nreq=%0d lat=%0d err=%b rdata=%h expected 0 2 1 0",
                     i, o_nreq, o_lat, o_err, o_rdata);
         end
      end
   endtask

   task automatic stray_rvalid(input string tag);
      int seen = 0;
      data_rvalid = 1'b1;
      data_rdata = 32'h5555_AAAA;
      @(negedge clk);
      data_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (resp_valid_o) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL stray_rvalid_%s: got %0d response cycles expected 0", tag, seen);
      end
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 100, 0);
      checks++;
      if (o_nreq !== TO || o_lat !== TO + 2 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
         errors++;
         $display("FAIL gnt_timeout: got nreq=%0d lat=%0d err=%b rdata=%h expected %0d %0d 1 0",
                  o_nreq, o_lat, o_err, o_rdata, TO, TO + 2);
      end
      stray_rvalid("after_gnt_timeout");
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 100);
      checks++;
      if (o_nreq !== 1 || o_lat !== TO + 3 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rvalid_timeout: got nreq=%0d lat=%0d err=%b rdata=%h expected 1 %0d 1 0",
                  o_nreq, o_lat, o_err, o_rdata, TO + 3);
      end
      stray_rvalid("late_response");
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h80;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (data_req_o !== 1'b0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: got req=%b rv=%b ready=%b expected 0 0 1",
                  data_req_o, resp_valid_o, req_ready_o);
      end
      data_rvalid = 1'b1;
      @(negedge clk);
      data_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (resp_valid_o) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL reset_mid_no_resp: got %0d response cycles expected 0", seen);
      end
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 0, 0);
      checks++;
      if (o_rdata !== 32'hCAFE_F00D || o_lat !== 3 || o_err !== 1'b0 || o_nreq !== 1) begin
         errors++;
         $display("FAIL reset_mid_recover: got rdata=%h lat=%0d err=%b nreq=%0d expected cafef00d 3 0 1",
                  o_rdata, o_lat, o_err, o_nreq);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         logic        we   = 1'($urandom_range(0, 1));
         logic        uns  = 1'($urandom_range(0, 1));
         logic [1:0]  size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         logic [31:0] addr = {18'h0, 14'($urandom)};
         logic [31:0] wd   = $urandom;
         logic [31:0] rd   = $urandom;
         int gw = ($urandom_range(0, 11) == 0) ? 40 : int'($urandom_range(0, 3));
         int rw = ($urandom_range(0, 11) == 0) ? 40 : int'($urandom_range(0, 3));
         int off, e_lat, e_nreq;
         logic e_err, e_timeout;
         logic [31:0] e_rdata;
         if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(14, 31));
         if ($urandom_range(0, 1) == 0 && size != 2'b11)
            addr = addr & ~((32'h1 << size) - 1);
         off = int'(addr % 4);
         e_err = m_err(size, addr);
         e_timeout = 1'b0;
         e_rdata = 32'h0;
         if (e_err) begin
            e_nreq = 0; e_lat = 2;
         end else if (gw >= TO) begin
            e_nreq = TO; e_lat = TO + 2; e_timeout = 1'b1;
         end else if (rw >= TO) begin
            e_nreq = gw + 1; e_lat = gw + 1 + TO + 2; e_timeout = 1'b1;
         end else begin
            e_nreq = gw + 1; e_lat = gw + rw + 3;
            if (!we) e_rdata = m_load(size, off, uns, rd);
         end
         run_txn(we, size, uns, addr, wd, rd, gw, rw);
         checks++;
         if (o_nreq !== e_nreq || o_lat !== e_lat || o_err !== (e_err | e_timeout) || o_rdata !== e_rdata) begin
            errors++;
            $display("FAIL rand_resp[%0d]: got nreq=%0d lat=%0d err=%b rdata=%h expected %0d %0d %b %h (we=%b sz=%0d u=%b a=%h rd=%h)",
                     n, o_nreq, o_lat, o_err, o_rdata, e_nreq, e_lat, e_err | e_timeout, e_rdata,
                     we, size, uns, addr, rd);
         end
         if (e_nreq > 0) begin
            checks++;
            if (o_be !== m_be(size, off) || o_addr !== (addr[13:0] & 14'h3FFC) || o_we !== we ||
                o_wdata !== (we ? m_wdata(size, wd) : 32'h0)) begin
               errors++;
               $display("FAIL rand_bus[%0d]: got be=%b addr=%h we=%b wdata=%h expected %b %h %b %h",
                        n, o_be, o_addr, o_we, o_wdata, m_be(size, off), addr[13:0] & 14'h3FFC, we,
                        we ? m_wdata(size, wd) : 32'h0);
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_word_store();
      test_byte_load();
      test_half_store();
      test_errors();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Initiator side of the core data port: converts single load/store requests from the pipeline into data_req/gnt/rvalid transactions toward the peripheral bus and data memory.
- Generates byte enables and write-data replication from access size and offset; extracts and sign/zero-extends load data.
- Flags misaligned accesses, out-of-range addresses and timeouts.
- One outstanding transaction at a time.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent waiting for gnt (REQ) or for rvalid (WAIT) before an error response.
- ADDR_W, 14: bus address width; request address bits above ADDR_W must be zero.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  pipeline request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned_i  in  1  zero-extend loads when 1
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, LSB-aligned
- resp_valid_o  out  1  one-cycle response pulse
- resp_rdata_o  out  32  extended load data (0 for stores and errors)
- resp_err_o  out  1  error flag, valid with resp_valid_o
- data_req_o  out  1  bus request
- data_we_o  out  1  bus write enable
- data_be_o  out  4  bus byte enables
- data_addr_o  out  ADDR_W  word-aligned byte address, bits [1:0] = 0
- data_wdata_o  out  32  bus write data
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  bus response valid
- data_rdata_i  in  32  bus read data

Behaviour:
- Reset: state IDLE, counter 0. Outputs after reset: req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0.
- Reset mid-transaction: the pending transaction is dropped and no response is issued. Bus outputs return to 0 on the next edge.
- States:
  - IDLE: req_ready_o=1. On accept, latch we, size, unsigned, addr and wdata.
    - Error (size 11; half with addr[0]=1; word with addr[1:0]≠0; addr[31:ADDR_W]≠0): go to ERR. No bus activity.
    - Otherwise go to REQ.
  - REQ: data_req_o=1, with all bus outputs driven from registers. On data_gnt_i go to WAIT. If the counter reaches TIMEOUT_CYCLES first, go to ERR.
  - WAIT: data_req_o=0. On data_rvalid_i, capture data_rdata_i and go to IDLE, issuing a normal response. If the counter reaches TIMEOUT_CYCLES first, go to ERR.
  - ERR: single cycle, returns to IDLE with resp_err_o=1.
- Counter clears on every state entry and saturates.
- Responses: resp_valid_o, resp_err_o and resp_rdata_o are registered and pulse for exactly one cycle, in the cycle after the rvalid or error decision. req_ready_o is high in that same cycle, so a new request may be accepted alongside the response.
- Nominal latency with gnt tied 1 and rvalid one cycle after req:
  - Accept at cycle T, data_req_o at T+1, rvalid at T+2, resp_valid_o at T+3.
  - Error response: resp_valid_o at T+2.
- data_rvalid_i is honoured only in WAIT and ignored in all other states. A late response after a timeout is discarded.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Write data: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
- Load data:
  - Shift right by 8*addr[1:0], then keep 8 or 16 bits.
  - Sign-extend from bit 7 or 15 unless req_unsigned_i; word loads pass through unchanged.
- Stores: resp_rdata_o=0. The store response is still gated by rvalid.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state enum IDLE/REQ/WAIT/ERR
- Sub-module lsu_align: purely combinational. Computes byte enables, write-data replication, misalign/range error, and load extraction/extension. Keeps the FSM file small.

Test Plan:
- Word store addr=0x0000_0104, wdata=0xDEADBEEF, gnt=1 -> data_be_o=4'b1111, data_addr_o=0x104, data_wdata_o=0xDEADBEEF during one data_req_o cycle; resp_valid_o 3 cycles after accept with err=0 and rdata=0.
- Byte load addr=0x203, bus rdata=0x80FF_1234, signed -> data_be_o=4'b1000, resp_rdata_o=0xFFFF_FF80. Repeat unsigned -> 0x0000_0080.
- Half store addr=0x0002, wdata=0x0000_ABCD -> data_be_o=4'b1100, data_wdata_o=0xABCD_ABCD.
- Misaligned word load addr=0x0006 and out-of-range addr=0x0001_0000 -> data_req_o never asserted; resp_valid_o at accept+2 with resp_err_o=1 and rdata=0.
- gnt held low 16 cycles -> data_req_o high for 16 cycles, then resp_err_o=1. A stray rvalid injected afterward while idle produces no resp_valid_o.
- Reset asserted during WAIT -> next cycle data_req_o=0, resp_valid_o stays 0, req_ready_o=1; a following word load completes normally.
